// File: rtl/tm_result_collector_if.sv
// Result-bus bundle between the TestModule-side producer, the capture FIFO and its consumer.
// Clock and reset stay outside this bundle as plain ports.
interface tm_result_collector_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
);
    localparam int LW = $clog2(DEPTH + 1);

    logic             pib_in_vld;
    logic             pib_flag_a;
    logic [2:0]       piv_data_3;
    logic             pib_flag_b;
    logic             pob_in_rdy;
    logic             pob_out_vld;
    logic [4:0]       pov_out_data_5;
    logic             pib_out_rdy;
    logic [CNT_W-1:0] pov_cnt_a;
    logic [CNT_W-1:0] pov_cnt_b;
    logic             pob_ovf;
    logic             pib_clr;
    logic [LW-1:0]    pov_level;

    modport slave (
        input  pib_in_vld, pib_flag_a, piv_data_3, pib_flag_b, pib_out_rdy, pib_clr,
        output pob_in_rdy, pob_out_vld, pov_out_data_5, pov_cnt_a, pov_cnt_b, pob_ovf, pov_level
    );

    modport master (
        output pib_in_vld, pib_flag_a, piv_data_3, pib_flag_b, pib_out_rdy, pib_clr,
        input  pob_in_rdy, pob_out_vld, pov_out_data_5, pov_cnt_a, pov_cnt_b, pob_ovf, pov_level
    );
endinterface

// File: rtl/tm_result_collector.sv
// Captures strobed TestModule result samples into a small ready/valid FIFO and
// keeps saturating rising-edge counters for both flags plus a sticky drop flag.
module tm_result_collector #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                  pib_clk,
    input  logic                  pib_rst_n,
    tm_result_collector_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [4:0]       mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr, rd_next;
    logic [LW-1:0]    level, level_after_pop, level_next;
    logic [4:0]       out_data, head_next, word;
    logic [CNT_W-1:0] cnt_a, cnt_b;
    logic             ovf, prev_a, prev_b;
    logic             in_rdy, out_vld, push, pop;

    assign in_rdy  = (level != LW'(DEPTH));
    assign out_vld = (level != '0);
    assign push    = bus.pib_in_vld & in_rdy;
    assign pop     = out_vld & bus.pib_out_rdy;
    assign word    = {bus.pib_flag_b, bus.piv_data_3, bus.pib_flag_a};

    assign rd_next         = rd_ptr + PW'(pop);
    assign level_after_pop = level - LW'(pop);
    assign level_next      = level_after_pop + LW'(push);

    // The head word is registered; when the FIFO drains to empty it keeps its last value.
    always_comb begin
        head_next = out_data;
        if (level_next != '0) begin
            head_next = (level_after_pop == '0) ? word : mem[rd_next];
        end
    end

    always_ff @(posedge pib_clk) begin
        if (push) mem[wr_ptr] <= word;
    end

    always_ff @(posedge pib_clk or negedge pib_rst_n) begin
        if (!pib_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            out_data <= '0;
        end else begin
            wr_ptr   <= wr_ptr + PW'(push);
            rd_ptr   <= rd_next;
            level    <= level_next;
            out_data <= head_next;
        end
    end

    // Clear overrides increments and drops, but a same-cycle accepted sample still seeds prev.
    always_ff @(posedge pib_clk or negedge pib_rst_n) begin
        if (!pib_rst_n) begin
            cnt_a  <= '0;
            cnt_b  <= '0;
            ovf    <= 1'b0;
            prev_a <= 1'b0;
            prev_b <= 1'b0;
        end else if (bus.pib_clr) begin
            cnt_a  <= '0;
            cnt_b  <= '0;
            ovf    <= 1'b0;
            prev_a <= push & bus.pib_flag_a;
            prev_b <= push & bus.pib_flag_b;
        end else begin
            if (bus.pib_in_vld && !in_rdy) ovf <= 1'b1;
            if (push) begin
                prev_a <= bus.pib_flag_a;
                prev_b <= bus.pib_flag_b;
                if (bus.pib_flag_a && !prev_a && (cnt_a != '1)) cnt_a <= cnt_a + 1'b1;
                if (bus.pib_flag_b && !prev_b && (cnt_b != '1)) cnt_b <= cnt_b + 1'b1;
            end
        end
    end

    assign bus.pob_in_rdy     = in_rdy;
    assign bus.pob_out_vld    = out_vld;
    assign bus.pov_out_data_5 = out_data;
    assign bus.pov_cnt_a      = cnt_a;
    assign bus.pov_cnt_b      = cnt_b;
    assign bus.pob_ovf        = ovf;
    assign bus.pov_level      = level;
endmodule

// File: tb/tb_tm_result_collector.sv
// Directed plus randomized bench for tm_result_collector against a queue-based reference model.
module tb_tm_result_collector;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tm_result_collector_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    tm_result_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .pib_clk   (clk),
        .pib_rst_n (rst_n),
        .bus       (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [4:0] q [$];
    int         m_cnt_a, m_cnt_b;
    bit         m_ovf, m_pa, m_pb;
    logic [4:0] m_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_cnt_a = 0;
        m_cnt_b = 0;
        m_ovf   = 1'b0;
        m_pa    = 1'b0;
        m_pb    = 1'b0;
        m_last  = 5'd0;
    endtask

    task automatic check_all();
        chk("level",    32'(bus.pov_level),      32'(q.size()));
        chk("out_vld",  32'(bus.pob_out_vld),    32'(q.size() != 0));
        chk("in_rdy",   32'(bus.pob_in_rdy),     32'(q.size() != DEPTH));
        chk("out_data", 32'(bus.pov_out_data_5), 32'(m_last));
        chk("cnt_a",    32'(bus.pov_cnt_a),      32'(m_cnt_a));
        chk("cnt_b",    32'(bus.pov_cnt_b),      32'(m_cnt_b));
        chk("ovf",      32'(bus.pob_ovf),        32'(m_ovf));
    endtask

    task automatic step(input bit vld, input bit a, input logic [2:0] d, input bit b,
                        input bit ordy, input bit clr);
        bit full, push, pop;
        @(negedge clk);
        bus.pib_in_vld  = vld;
        bus.pib_flag_a  = a;
        bus.piv_data_3  = d;
        bus.pib_flag_b  = b;
        bus.pib_out_rdy = ordy;
        bus.pib_clr     = clr;
        full = (q.size() == DEPTH);
        push = vld && !full;
        pop  = (q.size() != 0) && ordy;
        @(posedge clk);
        if (pop)  void'(q.pop_front());
        if (push) q.push_back({b, d, a});
        if (q.size() != 0) m_last = q[0];
        if (clr) begin
            m_cnt_a = 0;
            m_cnt_b = 0;
            m_ovf   = 1'b0;
            m_pa    = push && a;
            m_pb    = push && b;
        end else begin
            if (vld && full) m_ovf = 1'b1;
            if (push) begin
                if (a && !m_pa && m_cnt_a < CMAX) m_cnt_a++;
                if (b && !m_pb && m_cnt_b < CMAX) m_cnt_b++;
                m_pa = a;
                m_pb = b;
            end
        end
        #1;
        check_all();
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, 1'b0, 3'd0, 1'b0, ordy, 1'b0);
    endtask

    initial begin
        bus.pib_in_vld  = 1'b0;
        bus.pib_flag_a  = 1'b0;
        bus.piv_data_3  = 3'd0;
        bus.pib_flag_b  = 1'b0;
        bus.pib_out_rdy = 1'b0;
        bus.pib_clr     = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        idle(1'b0);
        idle(1'b0);

        // Single push appears one cycle later as {b,d,a}
        step(1'b1, 1'b1, 3'b101, 1'b0, 1'b0, 1'b0);
        chk("first_word", 32'(bus.pov_out_data_5), 32'h0B);
        chk("first_cnt_a", 32'(bus.pov_cnt_a), 32'd1);
        repeat (2) idle(1'b1);

        // Overfill: fifth push dropped, then drain in order
        for (int i = 0; i < 5; i++) step(1'b1, i[0], 3'(i + 2), ~i[0], 1'b0, 1'b0);
        chk("fill_level", 32'(bus.pov_level), 32'd4);
        chk("fill_ovf",   32'(bus.pob_ovf),   32'd1);
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        repeat (5) idle(1'b1);

        // Full with simultaneous strobe and pop: pop only, and the strobe counts as a drop
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 3'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 3'd7, 1'b1, 1'b1, 1'b0);
        chk("fullpop_level", 32'(bus.pov_level), 32'd3);
        chk("fullpop_ovf",   32'(bus.pob_ovf),   32'd1);
        repeat (4) idle(1'b1);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 3) != 0), 1'($urandom), 3'($urandom), 1'($urandom),
                 1'($urandom), ($urandom_range(0, 40) == 0));
        end
        repeat (5) idle(1'b1);

        // Saturation of cnt_a, then clear
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 600; i++) step(1'b1, i[0], 3'(i), 1'b0, 1'b1, 1'b0);
        chk("sat_cnt_a", 32'(bus.pov_cnt_a), 32'(CMAX));
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
        chk("clr_cnt_a", 32'(bus.pov_cnt_a), 32'd0);
        repeat (3) idle(1'b1);

        // Asynchronous reset mid-drain with level 3
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 3'(i), 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        chk("pre_rst_level", 32'(bus.pov_level), 32'd3);
        @(negedge clk);
        bus.pib_out_rdy = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        bus.pib_out_rdy = 1'b0;
        rst_n = 1'b1;
        step(1'b1, 1'b0, 3'b110, 1'b1, 1'b0, 1'b0);
        chk("post_rst_level", 32'(bus.pov_level), 32'd1);
        chk("post_rst_word",  32'(bus.pov_out_data_5), 32'h1C);
        repeat (3) idle(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
